// File: rtl/display_source_arbiter.sv
// Purpose: shares one 4-digit seven-segment display among four requesters
// (score, ball X, ball Y, debug). Rotates among active requesters on a fixed
// dwell, lets a requester preempt with an urgent override for a hold time,
// and supports a manual lock onto one source. Paced by the driver's tick.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   tick                one-cycle pacing strobe from the display driver
//   req[3:0]            source i has a value to show
//   urgent[3:0]         source i requests override (needs req[i])
//   val0..val3          16-bit display value of each source
//   lock, lock_sel      pin the display to lock_sel while lock=1
//   disp_value          registered value to the driver (1-cycle lag on cur_src)
//   disp_enable         display enable (1 in ROTATE/OVERRIDE/LOCKED)
//   cur_src             index of the source currently shown
//   overriding          1 while in OVERRIDE
module display_source_arbiter #(
  parameter int unsigned DWELL_TICKS = 600,
  parameter int unsigned HOLD_TICKS  = 300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [3:0]  req,
  input  logic [3:0]  urgent,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  input  logic        lock,
  input  logic [1:0]  lock_sel,
  output logic [15:0] disp_value,
  output logic        disp_enable,
  output logic [1:0]  cur_src,
  output logic        overriding
);

  localparam int unsigned CW = 12;
  localparam int unsigned VW = 16;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ROTATE   = 2'd1,
    S_OVERRIDE = 2'd2,
    S_LOCKED   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cur_d, saved_q, saved_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   val_sel, disp_value_d;
  logic            disp_enable_d, overriding_d;
  logic [3:0]      hit;

  // First requesting index strictly after base (wrapping); base itself last.
  function automatic logic [1:0] next_after(input logic [1:0] base,
                                            input logic [3:0] r);
    logic [1:0] idx;
    next_after = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) next_after = idx;
    end
  endfunction

  // base if it is still requesting, otherwise the next requester after it.
  function automatic logic [1:0] resume_at(input logic [1:0] base,
                                           input logic [3:0] r);
    resume_at = r[base] ? base : next_after(base, r);
  endfunction

  // Value of the currently registered source.
  always_comb begin
    val_sel = val0;
    unique case (cur_src)
      2'd0: val_sel = val0;
      2'd1: val_sel = val1;
      2'd2: val_sel = val2;
      2'd3: val_sel = val3;
      default: val_sel = val0;
    endcase
  end

  // Next-state and output logic; precedence lock > urgent > req drop > tick.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_src;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    hit     = urgent & req;

    if (lock) begin
      state_d = S_LOCKED;
      cur_d   = lock_sel;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_LOCKED: begin
          // Urgent is not honoured on the release edge; a held level re-arms next cycle.
          cnt_d = '0;
          if (req == 4'b0000) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ROTATE;
            cur_d   = resume_at(lock_sel, req);
          end
        end
        S_IDLE: begin
          if (hit != 4'b0000) begin
            state_d = S_OVERRIDE;
            cur_d   = next_after(2'd3, hit);
            cnt_d   = '0;
          end else if (req != 4'b0000) begin
            state_d = S_ROTATE;
            cur_d   = next_after(2'd3, req);
            cnt_d   = '0;
          end
        end
        S_ROTATE: begin
          if (hit != 4'b0000) begin
            state_d = S_OVERRIDE;
            saved_d = cur_src;
            cur_d   = next_after(2'd3, hit);
            cnt_d   = '0;
          end else if (!req[cur_src] || (tick && cnt_q == DWELL_LAST)) begin
            // Req drop and dwell expiry share one advance, never two.
            cnt_d = '0;
            if (req == 4'b0000) state_d = S_IDLE;
            else                cur_d   = next_after(cur_src, req);
          end else if (tick) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_OVERRIDE: begin
          if (hit != 4'b0000) begin
            cur_d = next_after(2'd3, hit);
            cnt_d = '0;
          end else if (!req[cur_src] || (tick && cnt_q == HOLD_LAST)) begin
            cnt_d = '0;
            if (req == 4'b0000) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_ROTATE;
              cur_d   = resume_at(saved_q, req);
            end
          end else if (tick) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    disp_enable_d = (state_d != S_IDLE);
    overriding_d  = (state_d == S_OVERRIDE);
    disp_value_d  = (state_d == S_IDLE) ? '0 : val_sel;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cur_src     <= 2'd0;
      saved_q     <= 2'd0;
      cnt_q       <= '0;
      disp_value  <= '0;
      disp_enable <= 1'b0;
      overriding  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src     <= cur_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      disp_value  <= disp_value_d;
      disp_enable <= disp_enable_d;
      overriding  <= overriding_d;
    end
  end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Bench for display_source_arbiter (DWELL_TICKS=4, HOLD_TICKS=2, tick every
// 5 clk). A per-cycle reference model feeds a scoreboard queue; a vector table
// holds hand-derived checkpoints; short hand sequences cover async reset and
// the same-cycle tick/req-drop case.
module tb_display_source_arbiter;

  localparam int unsigned DW = 4;
  localparam int unsigned HW = 2;

  localparam int S_IDLE = 0, S_ROT = 1, S_OVR = 2, S_LOCK = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [3:0]  req, urgent;
  logic [15:0] val0, val1, val2, val3;
  logic        lock;
  logic [1:0]  lock_sel;
  logic [15:0] disp_value;
  logic        disp_enable;
  logic [1:0]  cur_src;
  logic        overriding;

  display_source_arbiter #(.DWELL_TICKS(DW), .HOLD_TICKS(HW)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .req(req), .urgent(urgent),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .lock(lock), .lock_sel(lock_sel),
    .disp_value(disp_value), .disp_enable(disp_enable),
    .cur_src(cur_src), .overriding(overriding)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  src;
    logic        en;
    logic        ovr;
    logic [15:0] val;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] urg;
    logic       lock;
    logic [1:0] lsel;
    int         cyc;
    int         ticks;
    logic [1:0] exp_src;
    logic       exp_en;
    logic       exp_ovr;
  } vec_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state.
  int          m_state;
  logic [1:0]  m_cur, m_saved;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mval(input logic [1:0] s);
    case (s)
      2'd0: return val0;
      2'd1: return val1;
      2'd2: return val2;
      default: return val3;
    endcase
  endfunction

  // Search forward from b+1 around to b inclusive.
  function automatic logic [1:0] m_next(input logic [1:0] b, input logic [3:0] r);
    int off = 1;
    logic [1:0] c;
    while (off <= 4) begin
      c = 2'((int'(b) + off) % 4);
      if (r[c]) return c;
      off++;
    end
    return b;
  endfunction

  function automatic logic [1:0] m_lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_cur = 2'd0; m_saved = 2'd0; m_cnt = 0;
    sb_q.delete();
  endtask

  // Advance the model across the upcoming edge and queue its outputs.
  task automatic model_step();
    int ns, nn, lim;
    logic [1:0] nc, nsv;
    logic [3:0] hit;
    exp_t e;
    ns = m_state; nc = m_cur; nsv = m_saved; nn = m_cnt;
    hit = urgent & req;
    lim = (m_state == S_OVR) ? HW : DW;
    if (lock) begin
      ns = S_LOCK; nc = lock_sel; nn = 0;
    end else if (m_state == S_LOCK) begin
      nn = 0;
      if (req == 0) ns = S_IDLE;
      else begin ns = S_ROT; nc = req[lock_sel] ? lock_sel : m_next(lock_sel, req); end
    end else if (hit != 0) begin
      if (m_state == S_ROT) nsv = m_cur;
      ns = S_OVR; nc = m_lowest(hit); nn = 0;
    end else if (m_state == S_IDLE) begin
      if (req != 0) begin ns = S_ROT; nc = m_lowest(req); nn = 0; end
    end else if (!req[m_cur] || (tick && m_cnt == lim - 1)) begin
      nn = 0;
      if (req == 0) ns = S_IDLE;
      else if (m_state == S_ROT) nc = m_next(m_cur, req);
      else begin ns = S_ROT; nc = req[m_saved] ? m_saved : m_next(m_saved, req); end
    end else if (tick) begin
      nn = m_cnt + 1;
    end
    e.src = nc;
    e.en  = (ns != S_IDLE);
    e.ovr = (ns == S_OVR);
    e.val = (ns == S_IDLE) ? 16'h0 : mval(m_cur);
    sb_q.push_back(e);
    m_state = ns; m_cur = nc; m_saved = nsv; m_cnt = nn;
  endtask

  task automatic cycle(input logic t);
    exp_t e;
    tick = t;
    model_step();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_empty: no expected entry at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      check("sb_cur_src",     32'(cur_src),     32'(e.src));
      check("sb_disp_enable", 32'(disp_enable), 32'(e.en));
      check("sb_overriding",  32'(overriding),  32'(e.ovr));
      check("sb_disp_value",  32'(disp_value),  32'(e.val));
    end
    tick = 1'b0;
  endtask

  task automatic tick_periods(input int n);
    repeat (n) begin
      repeat (4) cycle(1'b0);
      cycle(1'b1);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    req = v.req; urgent = v.urg; lock = v.lock; lock_sel = v.lsel;
    repeat (v.cyc) cycle(1'b0);
    tick_periods(v.ticks);
    check($sformatf("vec%0d_cur_src", idx),     32'(cur_src),     32'(v.exp_src));
    check($sformatf("vec%0d_disp_enable", idx), 32'(disp_enable), 32'(v.exp_en));
    check($sformatf("vec%0d_overriding", idx),  32'(overriding),  32'(v.exp_ovr));
  endtask

  vec_t vecs[21];

  initial begin
    //          req      urg      lk    lsel  cyc tk  src  en    ovr
    vecs[0]  = '{4'b1011, 4'b0000, 1'b0, 2'd0, 1, 0,  2'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b1011, 4'b0000, 1'b0, 2'd0, 0, 4,  2'd1, 1'b1, 1'b0};
    vecs[2]  = '{4'b1011, 4'b0000, 1'b0, 2'd0, 0, 4,  2'd3, 1'b1, 1'b0};
    // async reset + release happen here
    vecs[3]  = '{4'b1011, 4'b0000, 1'b0, 2'd0, 0, 4,  2'd1, 1'b1, 1'b0};
    vecs[4]  = '{4'b1011, 4'b0000, 1'b0, 2'd0, 0, 4,  2'd3, 1'b1, 1'b0};
    vecs[5]  = '{4'b1011, 4'b0000, 1'b0, 2'd0, 0, 4,  2'd0, 1'b1, 1'b0};
    vecs[6]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 2, 0,  2'd2, 1'b1, 1'b0};
    vecs[7]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 0, 12, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1, 0,  2'd2, 1'b0, 1'b0};
    vecs[9]  = '{4'b0111, 4'b0000, 1'b0, 2'd0, 1, 0,  2'd0, 1'b1, 1'b0};
    vecs[10] = '{4'b0111, 4'b0000, 1'b0, 2'd0, 0, 4,  2'd1, 1'b1, 1'b0};
    vecs[11] = '{4'b0111, 4'b0100, 1'b0, 2'd0, 1, 0,  2'd2, 1'b1, 1'b1};
    vecs[12] = '{4'b0111, 4'b0000, 1'b0, 2'd0, 0, 1,  2'd2, 1'b1, 1'b1};
    vecs[13] = '{4'b0111, 4'b0000, 1'b0, 2'd0, 0, 1,  2'd1, 1'b1, 1'b0};
    vecs[14] = '{4'b1010, 4'b1010, 1'b0, 2'd0, 1, 0,  2'd1, 1'b1, 1'b1};
    vecs[15] = '{4'b1000, 4'b0000, 1'b0, 2'd0, 1, 0,  2'd3, 1'b1, 1'b0};
    vecs[16] = '{4'b0000, 4'b0000, 1'b1, 2'd3, 1, 0,  2'd3, 1'b1, 1'b0};
    vecs[17] = '{4'b0001, 4'b0001, 1'b1, 2'd3, 3, 0,  2'd3, 1'b1, 1'b0};
    vecs[18] = '{4'b0001, 4'b0000, 1'b1, 2'd1, 1, 0,  2'd1, 1'b1, 1'b0};
    vecs[19] = '{4'b0001, 4'b0000, 1'b0, 2'd1, 1, 0,  2'd0, 1'b1, 1'b0};
    vecs[20] = '{4'b0111, 4'b0000, 1'b0, 2'd0, 0, 3,  2'd0, 1'b1, 1'b0};

    reset_n = 1'b0; tick = 1'b0; req = 4'b0000; urgent = 4'b0000;
    lock = 1'b0; lock_sel = 2'd0;
    val0 = 16'h1111; val1 = 16'h2222; val2 = 16'hBEEF; val3 = 16'h3333;
    model_reset();

    #2;
    check("por_disp_enable", 32'(disp_enable), 32'd0);
    check("por_cur_src",     32'(cur_src),     32'd0);
    check("por_disp_value",  32'(disp_value),  32'd0);
    check("por_overriding",  32'(overriding),  32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i <= 2; i++) apply(vecs[i], i);

    // Asynchronous reset mid-rotation (showing source 3), between edges.
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_disp_enable", 32'(disp_enable), 32'd0);
    check("arst_cur_src",     32'(cur_src),     32'd0);
    check("arst_disp_value",  32'(disp_value),  32'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle(1'b0);
    check("arst_release_src", 32'(cur_src), 32'd0);

    for (int i = 3; i <= 20; i++) apply(vecs[i], i);

    // Counter is at DWELL-1: tick expiry and req[0] drop on the same edge.
    req = 4'b0110;
    cycle(1'b1);
    check("tick_drop_single_advance", 32'(cur_src), 32'd1);
    cycle(1'b0);
    cycle(1'b0);
    check("tick_drop_settled", 32'(cur_src), 32'd1);

    // Value change on the shown source appears with one cycle of lag.
    val1 = 16'hA5A5;
    cycle(1'b0);
    check("val_change_lag", 32'(disp_value), 32'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Shares the single 4-digit seven-segment display among four requesters: score, ball X, ball Y and a debug word.
- Rotates the shown value among active requesters on a fixed dwell. Lets a requester briefly preempt with an urgent override, and supports a manual lock onto one source.
- Sits directly upstream of the display driver. It paces off the driver's `tick` output (~300 Hz) and drives the driver's `value` and `enable` inputs.

Parameters:
- DWELL_TICKS, 600, ticks each source is shown during rotation (~2 s); legal 2..4095
- HOLD_TICKS, 300, ticks an urgent override is held (~1 s); legal 2..4095

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle pacing strobe from the display driver
- req  input  4  req[i]=1: source i has a value to show
- urgent  input  4  urgent[i]=1 (level): source i requests override; only effective when req[i]=1
- val0, val1, val2, val3  input  16 each  display value of source 0..3
- lock  input  1  1 = pin the display to lock_sel
- lock_sel  input  2  source index used while lock=1
- disp_value  output  16  value to the display driver
- disp_enable  output  1  display enable
- cur_src  output  2  index of the source currently shown
- overriding  output  1  1 while in OVERRIDE state

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE
  - cur_src=0, saved_src=0, counter=0
  - disp_value=0, disp_enable=0, overriding=0
- States: IDLE, ROTATE, OVERRIDE, LOCKED.
- Precedence, evaluated each clk edge: lock > urgent > current source's req dropping > tick expiry.
- IDLE:
  - disp_enable=0, disp_value=0.
  - Any req → ROTATE with cur_src = lowest-index requester, counter=0.
- ROTATE:
  - counter increments on tick.
  - On a tick with counter==DWELL_TICKS-1: cur_src advances round-robin to the next requesting index after cur_src (wrap 3→0), counter=0.
  - If cur_src is the only requester, it stays and counter resets to 0.
  - If req[cur_src]=0: next edge moves to the next requester, counter=0. If there are no requesters → IDLE.
  - Req-drop beats a same-cycle tick expiry; the move happens once, not twice.
- Urgent (from IDLE, ROTATE or OVERRIDE):
  - Condition: any (urgent[i] & req[i]).
  - Effect: → OVERRIDE with cur_src = lowest such i, counter=0.
  - On entry from ROTATE, saved_src is captured from cur_src. In OVERRIDE, saved_src is kept.
  - Urgent asserted during OVERRIDE restarts the hold (counter=0) and may switch cur_src.
- OVERRIDE:
  - overriding=1; counter increments on tick.
  - On a tick with counter==HOLD_TICKS-1, or if req[cur_src] drops:
    - return to ROTATE at saved_src if req[saved_src]=1, else next requester after saved_src, counter=0;
    - if there are no requesters → IDLE.
  - Urgent level still high at expiry re-enters OVERRIDE on the following edge. This is intended: a held urgent keeps the display.
- LOCKED:
  - Entered from any state when lock=1.
  - cur_src=lock_sel (tracks lock_sel changes each cycle); disp_enable=1 regardless of req; counter held at 0; urgent ignored and not queued.
  - When lock falls: → ROTATE at lock_sel if it is requesting, else next requester after lock_sel; if there are no requesters → IDLE.
- Output timing:
  - disp_value is registered: it equals val[cur_src] as sampled one cycle earlier, i.e. 1-cycle latency from a cur_src change or a value change.
  - disp_enable=1 in ROTATE, OVERRIDE and LOCKED.
  - cur_src and overriding are registered state outputs.
- Counters: 12-bit, never wrap; the compare is against the parameter minus 1.
- tick during IDLE is ignored.

Test Plan (DWELL_TICKS=4, HOLD_TICKS=2, tick every 5 clk):
- Reset mid-rotation with req=4'b1011: drop reset_n asynchronously → disp_enable=0, cur_src=0, disp_value=0 immediately, without waiting for a clk edge. Release with req=4'b1011 → ROTATE cur_src=0. After 4 ticks cur_src=1, after 4 more cur_src=3, then wrap to 0. disp_value tracks val0/val1/val3 with 1-cycle lag.
- Only req[2]=1, val2=16'hBEEF: cur_src stays 2 across 12 ticks; disp_value=16'hBEEF; disp_enable=1. Drop req → IDLE next edge, disp_enable=0.
- In ROTATE showing src 1 with req=4'b0111: pulse urgent[2] for 1 cycle → overriding=1, cur_src=2. After 2 ticks, overriding=0 and cur_src=1 with counter restarted.
- Assert urgent[1] and urgent[3] together with req=4'b1010 → cur_src=1 (lowest index). Drop req[1] mid-hold → ROTATE at saved source or next requester.
- lock=1, lock_sel=3, req=0 → disp_enable=1, cur_src=3. Urgent[0] with req[0] is ignored. Release lock with req=4'b0001 → ROTATE cur_src=0.
- Same-cycle tick expiry and req[cur_src] drop with req=4'b0111 at cur_src=0 → cur_src=1 (single advance, not 2).
